// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t      : fetch FSM states (IDLE, FETCH, HALTED)
//   fetch_entry_t      : {pc, instr} pair as seen by decode, at the default widths
//   HALT_INSTR_DEFAULT : instruction pattern that stops fetch
package fetch_pkg;

  localparam int FETCH_PC_WIDTH    = 32;
  localparam int FETCH_INSTR_WIDTH = 32;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_WIDTH-1:0]    pc;
    logic [FETCH_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
//   clk, reset : clock, asynchronous active-high reset
//   push/wdata : write one entry (ignored when full or flushing)
//   pop/rdata  : rdata is the head entry, combinational, all-zero when empty;
//                pop removes it (ignored when empty or flushing)
//   flush      : discard every entry and return both pointers to 0
//   full, empty, count : occupancy status
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage has no reset: contents are only observable through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage in front of a combinational instruction memory.
// Owns the program counter, buffers {pc, instr} pairs in fetch_fifo and hands
// them to decode. Stops fetching on HALT_INSTR; a redirect flushes the buffer.
//   clk, reset       : clock, asynchronous active-high reset
//   F_PC             : registered PC driven to instruction memory
//   Instr            : memory data for F_PC, same cycle
//   fetch_en         : 0 holds the PC and stops pushes
//   redirect_valid   : taken branch/jump; flush and load redirect_pc
//   redirect_pc      : new fetch address
//   D_valid/D_ready  : decode handshake; D_PC/D_Instr carry the head entry
//   halted           : FSM is in HALTED
//   dbg_state        : current FSM state
//   dbg_count        : current fetch buffer occupancy
// Optional: define FETCH_PERF_CNT_EN to add saturating counters
//   fetch_count (entries pushed) and flush_count (entries discarded by redirect).
//
// Handshake: an entry transfers on every rising edge where D_valid && D_ready.
// D_valid never depends on D_ready, and D_PC/D_Instr hold steady while D_valid
// is high and D_ready is low. D_valid drops in a redirect cycle because the
// buffer is being discarded on that edge.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int                       INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter int                       FIFO_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0]      RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0]      PC_STEP     = PC_WIDTH'(1),
  parameter logic [INSTR_WIDTH-1:0]   HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [PC_WIDTH-1:0]           F_PC,
  input  logic [INSTR_WIDTH-1:0]        Instr,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  output logic                          D_valid,
  input  logic                          D_ready,
  output logic [PC_WIDTH-1:0]           D_PC,
  output logic [INSTR_WIDTH-1:0]        D_Instr,
  output logic                          halted,
  output fetch_state_t                  dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   fetch_count,
  output logic [31:0]                   flush_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = PC_WIDTH + INSTR_WIDTH;

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                is_halt;
  logic [CW-1:0]       count;
  logic [EW-1:0]       head;

  assign is_halt = (Instr == HALT_INSTR);
  // Redirect suppresses both sides of the buffer: the flush wins on that edge.
  assign push    = (state == FETCH) && fetch_en && !full && !redirect_valid;
  assign D_valid = !empty && !redirect_valid;
  assign pop     = D_valid && D_ready;

  assign F_PC      = pc_q;
  assign D_PC      = head[EW-1:INSTR_WIDTH];
  assign D_Instr   = head[INSTR_WIDTH-1:0];
  assign halted    = (state == HALTED);
  assign dbg_state = state;
  assign dbg_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      state_nxt = fetch_en ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            state_nxt = FETCH;
          end
        end
        FETCH: begin
          if (!fetch_en) begin
            state_nxt = IDLE;
          end else if (push && is_halt) begin
            // The HALT entry is buffered but the PC stays on it.
            state_nxt = HALTED;
          end else if (push) begin
            pc_nxt = pc_q + PC_STEP;
          end
        end
        HALTED: begin
          state_nxt = HALTED;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_q, Instr}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, flush_count} + 33'(count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect_valid) begin
        flush_count <= flush_sum[32] ? '1 : flush_sum[31:0];
      end
    end
  end
`endif

endmodule
